control_unit_seq: RTL

//  Parametrised multi-cycle control FSM for the microprocessor core; successor to the 8-bit control unit.

---
 rtl/control_unit_seq_if.sv | 71 +++++++
 rtl/control_unit_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_seq_if.sv
// rtl/control_unit_seq_if.sv - control unit to datapath signal bundle
// illegal_op exists only when CU_ILLEGAL_TRAP_EN is defined.
interface control_unit_seq_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int INSTR_W = 8 + 2 * DATA_W;

  logic [INSTR_W-1:0] instr_word;
  logic               instr_valid;
  logic [ADDR_W-1:0]  pc_value;
  logic               mar_load;
  logic               ir_load;
  logic               pc_inc;
  logic               pc_load_en;
  logic [ADDR_W-1:0]  pc_load_val;
  logic               reg_rd_en;
  logic [DATA_W-1:0]  rd_addr1;
  logic [DATA_W-1:0]  rd_addr2;
  logic               reg_wr_en;
  logic [DATA_W-1:0]  wr_addr;
  logic [DATA_W-1:0]  imm_data;
  logic [1:0]         path_sel;
  logic [7:0]         alu_sel;
  logic               alu_start;
  logic               alu_done;
  logic               mem_rd_en;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ready;
  logic               halted;
  logic               stack_err;
  logic [3:0]         state_out;
  logic [7:0]         opcode_out;

`ifdef CU_ILLEGAL_TRAP_EN
  logic               illegal_op;

  modport master (
    input  instr_word, instr_valid, pc_value, alu_done, mem_ready,
    output mar_load, ir_load, pc_inc, pc_load_en, pc_load_val,
    output reg_rd_en, rd_addr1, rd_addr2, reg_wr_en, wr_addr, imm_data, path_sel,
    output alu_sel, alu_start, mem_rd_en, mem_wr_en, mem_addr,
    output halted, stack_err, state_out, opcode_out, illegal_op
  );

  modport slave (
    output instr_word, instr_valid, pc_value, alu_done, mem_ready,
    input  mar_load, ir_load, pc_inc, pc_load_en, pc_load_val,
    input  reg_rd_en, rd_addr1, rd_addr2, reg_wr_en, wr_addr, imm_data, path_sel,
    input  alu_sel, alu_start, mem_rd_en, mem_wr_en, mem_addr,
    input  halted, stack_err, state_out, opcode_out, illegal_op
  );
`else
  modport master (
    input  instr_word, instr_valid, pc_value, alu_done, mem_ready,
    output mar_load, ir_load, pc_inc, pc_load_en, pc_load_val,
    output reg_rd_en, rd_addr1, rd_addr2, reg_wr_en, wr_addr, imm_data, path_sel,
    output alu_sel, alu_start, mem_rd_en, mem_wr_en, mem_addr,
    output halted, stack_err, state_out, opcode_out
  );

  modport slave (
    output instr_word, instr_valid, pc_value, alu_done, mem_ready,
    input  mar_load, ir_load, pc_inc, pc_load_en, pc_load_val,
    input  reg_rd_en, rd_addr1, rd_addr2, reg_wr_en, wr_addr, imm_data, path_sel,
    input  alu_sel, alu_start, mem_rd_en, mem_wr_en, mem_addr,
    input  halted, stack_err, state_out, opcode_out
  );
`endif
endinterface

// File: rtl/control_unit_seq.sv
// rtl/control_unit_seq.sv - multi-cycle fetch/decode/execute control FSM with return stack
// Define CU_ILLEGAL_TRAP_EN to trap undefined opcodes to TRAP_VEC; otherwise they execute as NOP.
module control_unit_seq #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 16,
  parameter logic [ADDR_W-1:0] TRAP_VEC    = 'hF0
) (
  input  logic                clk,
  input  logic                rst,
  control_unit_seq_if.master  bus
);
  localparam int INSTR_W = 8 + 2 * DATA_W;
  localparam int SP_W    = $clog2(STACK_DEPTH) + 1;

  localparam logic [7:0] OP_STR_IMM = 8'h01;
  localparam logic [7:0] OP_STR_DIR = 8'h02;
  localparam logic [7:0] OP_ALU_LO  = 8'h03;
  localparam logic [7:0] OP_ALU_HI  = 8'h17;
  localparam logic [7:0] OP_LOA_DIR = 8'h21;
  localparam logic [7:0] OP_MOV     = 8'h22;
  localparam logic [7:0] OP_JMP     = 8'h30;
  localparam logic [7:0] OP_CALL    = 8'h31;
  localparam logic [7:0] OP_RET     = 8'h32;
  localparam logic [7:0] OP_HALT    = 8'h3F;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_WAIT_IR  = 4'd1,
    S_DECODE   = 4'd2,
    S_STR_IMM  = 4'd3,
    S_STR_DIR  = 4'd4,
    S_LOA_MEM  = 4'd5,
    S_MOV      = 4'd6,
    S_ALU_RD   = 4'd7,
    S_ALU_WAIT = 4'd8,
    S_WB       = 4'd9,
    S_JMP      = 4'd10,
    S_CALL     = 4'd11,
    S_RET      = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  state_t            state, state_n;
  logic              run_q;
  logic [7:0]        op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [SP_W-1:0]   sp;
  logic              stack_err_q;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [7:0]        op_w;
  logic [DATA_W-1:0] a_w, b_w;
  logic              sp_full, sp_empty;
  logic [SP_W-2:0]   push_idx, pop_idx;
  logic              op_q_alu;

  assign op_w = bus.instr_word[INSTR_W-1 -: 8];
  assign a_w  = bus.instr_word[2*DATA_W-1 -: DATA_W];
  assign b_w  = bus.instr_word[DATA_W-1:0];

  assign sp_full  = (sp == SP_W'(STACK_DEPTH));
  assign sp_empty = (sp == '0);
  assign push_idx = sp[SP_W-2:0];
  assign pop_idx  = sp[SP_W-2:0] - (SP_W-1)'(1);
  assign op_q_alu = (op_q >= OP_ALU_LO) && (op_q <= OP_ALU_HI);

  // run_q keeps the first FETCH after reset idle so every output reads 0 while rst is held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FETCH;
      run_q       <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sp          <= '0;
      stack_err_q <= 1'b0;
    end else begin
      state <= state_n;
      run_q <= 1'b1;
      if (state == S_DECODE) begin
        op_q <= op_w;
        a_q  <= a_w;
        b_q  <= b_w;
      end
      if (state == S_CALL) begin
        if (sp_full) stack_err_q <= 1'b1;
        else         sp          <= sp + SP_W'(1);
      end
      if (state == S_RET) begin
        if (sp_empty) stack_err_q <= 1'b1;
        else          sp          <= sp - SP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CALL && !sp_full) stack_mem[push_idx] <= bus.pc_value;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   illegal_q <= 1'b0;
    else if (state == S_TRAP)  illegal_q <= 1'b1;
  end

  assign bus.illegal_op = illegal_q;
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    if (run_q) state_n = S_WAIT_IR;
      S_WAIT_IR:  if (bus.instr_valid) state_n = S_DECODE;
      S_DECODE: begin
        if      (op_w == OP_STR_IMM) state_n = S_STR_IMM;
        else if (op_w == OP_STR_DIR) state_n = S_STR_DIR;
        else if (op_w == OP_LOA_DIR) state_n = S_LOA_MEM;
        else if (op_w == OP_MOV)     state_n = S_MOV;
        else if (op_w == OP_JMP)     state_n = S_JMP;
        else if (op_w == OP_CALL)    state_n = S_CALL;
        else if (op_w == OP_RET)     state_n = S_RET;
        else if (op_w == OP_HALT)    state_n = S_HALT;
        else if (op_w >= OP_ALU_LO && op_w <= OP_ALU_HI) state_n = S_ALU_RD;
`ifdef CU_ILLEGAL_TRAP_EN
        else                         state_n = S_TRAP;
`else
        else                         state_n = S_FETCH;
`endif
      end
      S_STR_DIR:  if (bus.mem_ready) state_n = S_FETCH;
      S_LOA_MEM:  if (bus.mem_ready) state_n = S_WB;
      S_MOV:      state_n = S_WB;
      S_ALU_RD:   state_n = S_ALU_WAIT;
      S_ALU_WAIT: if (bus.alu_done) state_n = S_WB;
      S_HALT:     state_n = S_HALT;
      default:    state_n = S_FETCH;
    endcase
  end

  always_comb begin
    bus.mar_load    = 1'b0;
    bus.ir_load     = 1'b0;
    bus.pc_inc      = 1'b0;
    bus.pc_load_en  = 1'b0;
    bus.pc_load_val = '0;
    bus.reg_rd_en   = 1'b0;
    bus.rd_addr1    = '0;
    bus.rd_addr2    = '0;
    bus.reg_wr_en   = 1'b0;
    bus.wr_addr     = '0;
    bus.imm_data    = '0;
    bus.path_sel    = 2'b00;
    bus.alu_sel     = 8'h00;
    bus.alu_start   = 1'b0;
    bus.mem_rd_en   = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.halted      = 1'b0;
    case (state)
      S_FETCH:   bus.mar_load = run_q;
      S_WAIT_IR: begin
        bus.ir_load = !bus.instr_valid;
        bus.pc_inc  = bus.instr_valid;
      end
      S_STR_IMM: begin
        bus.reg_wr_en = 1'b1;
        bus.wr_addr   = a_q;
        bus.imm_data  = b_q;
        bus.path_sel  = 2'b10;
      end
      S_STR_DIR: begin
        bus.reg_rd_en = 1'b1;
        bus.rd_addr1  = a_q;
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = ADDR_W'(b_q);
      end
      S_LOA_MEM: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = ADDR_W'(b_q);
      end
      S_MOV: begin
        bus.reg_rd_en = 1'b1;
        bus.rd_addr1  = b_q;
      end
      S_ALU_RD: begin
        bus.reg_rd_en = 1'b1;
        bus.rd_addr1  = a_q;
        bus.rd_addr2  = b_q;
        bus.alu_sel   = op_q;
        bus.alu_start = 1'b1;
      end
      S_ALU_WAIT: begin
        bus.rd_addr1 = a_q;
        bus.rd_addr2 = b_q;
        bus.alu_sel  = op_q;
      end
      // Operand addresses and ALU select stay up through write-back so the ALU result is still valid.
      S_WB: begin
        bus.reg_wr_en = 1'b1;
        bus.wr_addr   = a_q;
        if (op_q == OP_LOA_DIR) begin
          bus.path_sel = 2'b01;
        end else if (op_q == OP_MOV) begin
          bus.rd_addr1 = b_q;
        end else if (op_q_alu) begin
          bus.rd_addr1 = a_q;
          bus.rd_addr2 = b_q;
          bus.alu_sel  = op_q;
        end
      end
      S_JMP: begin
        bus.pc_load_en  = 1'b1;
        bus.pc_load_val = ADDR_W'(a_q);
      end
      S_CALL: begin
        bus.pc_load_en  = !sp_full;
        bus.pc_load_val = sp_full ? '0 : ADDR_W'(a_q);
      end
      S_RET: begin
        bus.pc_load_en  = !sp_empty;
        bus.pc_load_val = sp_empty ? '0 : stack_mem[pop_idx];
      end
      S_HALT:    bus.halted = 1'b1;
      S_TRAP: begin
        bus.pc_load_en  = 1'b1;
        bus.pc_load_val = TRAP_VEC;
      end
      default: ;
    endcase
  end

  assign bus.stack_err  = stack_err_q;
  assign bus.state_out  = state;
  assign bus.opcode_out = op_q;
endmodule
